// File: rtl/exe_pkg.sv
// ----------------------------------------------------------------------------
// exe_pkg
// Shared types and constants for the pipelined execution unit.
//   op_e        : operation select encoding
//   *_BIT       : bit positions inside the 4-bit status word
//                 status = {SINGLE, EVEN, ERROR, OVF}
// ----------------------------------------------------------------------------
package exe_pkg;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_CMP = 2'b01,
        OP_SHL = 2'b10,
        OP_CHG = 2'b11
    } op_e;

    localparam int OVF_BIT    = 0;
    localparam int ERROR_BIT  = 1;
    localparam int EVEN_BIT   = 2;
    localparam int SINGLE_BIT = 3;

endpackage

// File: rtl/exe_alu_comb.sv
// ----------------------------------------------------------------------------
// exe_alu_comb
// Purely combinational datapath of the execution unit.
// Ports:
//   a, b    in  BITS  operands (b is subtrahend, shift amount or bit index)
//   op      in  op_e  operation select
//   out     out BITS  result, modulo 2^BITS
//   status  out 4     {SINGLE, EVEN, ERROR, OVF}
// ----------------------------------------------------------------------------
module exe_alu_comb
    import exe_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  op_e             op,
    output logic [BITS-1:0] out,
    output logic [3:0]      status
);

    // Wide enough to hold a bit index and also a zero count of 0..BITS.
    localparam int IDX_W = $clog2(BITS) + 1;

    logic               in_range;
    logic [IDX_W-1:0]   idx;
    logic [2*BITS-1:0]  shl_wide;
    logic [IDX_W-1:0]   zeros;
    logic               ovf;
    logic               err;

    // The full operand is compared so that any upper bits mark it out of range;
    // idx is only meaningful when in_range is set.
    assign in_range = (b < BITS'(BITS));
    assign idx      = b[IDX_W-1:0];
    assign shl_wide = {{BITS{1'b0}}, a} << idx;

    always_comb begin
        out = '0;
        ovf = 1'b0;
        err = 1'b0;
        case (op)
            OP_SUB: {ovf, out} = {1'b0, a} - {1'b0, b};
            OP_CMP: out = BITS'(a > b);
            OP_SHL: begin
                if (in_range) begin
                    out = shl_wide[BITS-1:0];
                    ovf = |shl_wide[2*BITS-1:BITS];
                end else begin
                    err = 1'b1;
                end
            end
            OP_CHG: begin
                if (in_range) begin
                    out = a ^ (BITS'(1) << idx);
                end else begin
                    out = a;
                    err = 1'b1;
                end
            end
            default: out = '0;
        endcase
    end

    always_comb begin
        zeros = '0;
        for (int i = 0; i < BITS; i++) begin
            zeros = zeros + IDX_W'(!out[i]);
        end
    end

    always_comb begin
        status             = '0;
        status[OVF_BIT]    = ovf;
        status[ERROR_BIT]  = err;
        status[EVEN_BIT]   = ~zeros[0];
        status[SINGLE_BIT] = (zeros == IDX_W'(1));
    end

endmodule

// File: rtl/exe_unit_pipe.sv
// ----------------------------------------------------------------------------
// exe_unit_pipe
// Two-stage pipelined execution unit with valid/ready on both sides.
// Stage 1 registers the operands, stage 2 registers result and status.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-low reset
//   in_a, in_b, i_op    operand/op beat, accepted when i_valid & o_ready
//   o_out, o_status     result and {SINGLE, EVEN, ERROR, OVF}
//   o_valid, i_ready    result handoff when both high
//   i_clr               synchronous clear of o_err_sticky and o_cnt
//   o_err_sticky        set once any handed-off result had ERROR=1
//   o_cnt               number of handoffs, wrapping
// ----------------------------------------------------------------------------
module exe_unit_pipe
    import exe_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [BITS-1:0]  in_a,
    input  logic [BITS-1:0]  in_b,
    input  logic [1:0]       i_op,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [BITS-1:0]  o_out,
    output logic [3:0]       o_status,
    output logic             o_valid,
    input  logic             i_ready,
    input  logic             i_clr,
    output logic             o_err_sticky,
    output logic [CNT_W-1:0] o_cnt
);

    logic            s1_valid;
    logic [BITS-1:0] s1_a;
    logic [BITS-1:0] s1_b;
    op_e             s1_op;

    logic [BITS-1:0] alu_out;
    logic [3:0]      alu_status;

    logic s2_load;
    logic accept;
    logic handoff;

    // Stage 2 may load whenever its current content leaves or it is empty,
    // so stage 1 can take a new beat even while a handoff is happening.
    assign s2_load = !o_valid || i_ready;
    assign o_ready = !s1_valid || s2_load;
    assign accept  = i_valid && o_ready;
    assign handoff = o_valid && i_ready;

    exe_alu_comb #(.BITS(BITS)) u_alu (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .out    (alu_out),
        .status (alu_status)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_valid     <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_op        <= OP_SUB;
            o_valid      <= 1'b0;
            o_out        <= '0;
            o_status     <= '0;
            o_err_sticky <= 1'b0;
            o_cnt        <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_op    <= op_e'(i_op);
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                o_valid <= s1_valid;
                if (s1_valid) begin
                    o_out    <= alu_out;
                    o_status <= alu_status;
                end
            end

            // A handoff on the same edge as i_clr still counts.
            if (handoff) begin
                o_cnt        <= i_clr ? CNT_W'(1) : o_cnt + CNT_W'(1);
                o_err_sticky <= o_status[ERROR_BIT] || (o_err_sticky && !i_clr);
            end else if (i_clr) begin
                o_cnt        <= '0;
                o_err_sticky <= 1'b0;
            end
        end
    end

endmodule
